multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath, which shares one memory and one ULA across cycles. It decodes OP/Funct once per instruction and steps a Moore state machine that drives the datapath's mux selects, write enables and ULA operation. It stalls on a memory-ready handshake and counts retired instructions. It sits beside the register file, ULA, instruction register and unified memory in the multi-cycle top level. It supports the same instruction set as the single-cycle decoder: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, ADDi, J.

## Interface
- Parameters
  - CNT_W, 32, width of the retired-instruction counter
- Ports
  - clk  in  1  single clock; all state updates on rising edge
  - rst_n  in  1  asynchronous, active-low reset
  - OP  in  6  opcode field, taken from the instruction register
  - Funct  in  6  function field, taken from the instruction register
  - MemReady  in  1  memory has completed the current access this cycle
  - PCWrite  out  1  unconditional PC write
  - Branch  out  1  conditional PC write; the top level forms the PC enable as PCWrite | (Branch & Zero)
  - IorD  out  1  memory address select: 0 = PC, 1 = ULAOut
  - IRWrite  out  1  instruction register load
  - MemWrite  out  1  memory write strobe
  - RegWrite  out  1  register file write
  - RegDst  out  1  write register select: 1 = rd, 0 = rt
  - MemtoReg  out  1  writeback select: 1 = memory data, 0 = ULAOut
  - ULASrcA  out  1  ULA A operand select: 0 = PC, 1 = register A
  - ULASrcB  out  2  ULA B operand select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
  - ULAControl  out  3  ULA operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
  - PCSrc  out  2  PC source: 00 = ULAResult, 01 = ULAOut, 10 = jump target
  - Illegal  out  1  one-cycle pulse on an unsupported OP or Funct
  - State  out  4  current state code, for debug
  - InstrCount  out  CNT_W  count of retired instructions

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused and must go to FETCH on the next edge.
- Outputs are a combinational decode of the state; Illegal is the only exception (see DECODE). Any output not listed for a state is 0, with ULASrcB=00 and ULAControl=010.
- FETCH: IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when it is 1.
- DECODE: ULASrcA=0, ULASrcB=11, ULAControl=010 (precomputes the branch target).
  - Next state by OP: 100011 or 101011 → MEMADR; 000000 with a supported Funct → EXEC; 000100 → BEQ; 001000 → ADDIEX; 000010 → JUMP.
  - Anything else → FETCH, with Illegal=1 for this cycle only. Illegal is a combinational function of state and OP/Funct.
- MEMADR: ULASrcA=1, ULASrcB=10, ULAControl=010. Go to MEMRD if OP=100011, otherwise MEMWR.
- MEMRD: IorD=1. Stay until MemReady=1, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold MemWrite until MemReady=1, then go to FETCH.
- EXEC: ULASrcA=1, ULASrcB=00. ULAControl by Funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BEQ: ULASrcA=1, ULASrcB=00, ULAControl=110, Branch=1, PCSrc=01. Go to FETCH.
- ADDIEX: ULASrcA=1, ULASrcB=10, ULAControl=010. Go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- JUMP: PCWrite=1, PCSrc=10. Go to FETCH.
- InstrCount increments by 1, wrapping modulo 2^CNT_W, on every edge that leaves one of these states for FETCH: MEMWB, MEMWR (only when MemReady=1), ALUWB, BEQ, ADDIWB, JUMP. An illegal DECODE does not count.

## Timing
- Reset: rst_n=0 forces State=FETCH and InstrCount=0 immediately, without waiting for a clock edge.
  - While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, Branch and Illegal are forced to 0. All other outputs hold their FETCH values.
  - Release of rst_n is sampled at the next rising edge of clk.
- Reset asserted mid-instruction abandons that instruction: no write enable asserts afterwards, and the counter does not increment.
- Cycles per instruction with MemReady held at 1: LW 5, SW 4, R-type 4, ADDi 4, BEQ 3, J 3, illegal 2. Each cycle MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- OP and Funct are sampled only in DECODE, MEMADR and EXEC. The IR is stable in those states because IRWrite is asserted only in FETCH.

## Test plan
- Reset: hold rst_n=0 while clk toggles, then release → State=0, InstrCount=0, all write enables 0. With OP=100011 and MemReady=1: State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; InstrCount=1.
- SW with MemReady=0 for 3 cycles in MEMWR → MemWrite held high for 4 cycles and State stays at 5. Then FETCH follows, and the total instruction time is 7 cycles.
- Each R-type Funct (100000, 100010, 100100, 100101, 101010) → ULAControl in EXEC is 010, 110, 000, 001, 111 respectively, and ALUWB has RegDst=1.
- Illegal inputs: OP=000000 with Funct=000111, then OP=111111 → Illegal pulses for one cycle in DECODE each time, the next state is FETCH, and InstrCount is unchanged.
- Mixed stream of BEQ, J and ADDi → 3, 3 and 4 cycles. BEQ shows Branch=1, PCSrc=01; J shows PCWrite=1, PCSrc=10; InstrCount advances by 3.
- rst_n asserted during ADDIEX → State=0 asynchronously, RegWrite is never asserted, and InstrCount=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle MIPS datapath: decodes OP/Funct once per
// instruction and steps a Moore FSM that drives mux selects, write enables and the ULA op.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OP,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [2:0]       ULAControl,
  output logic [1:0]       PCSrc,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic       funct_ok;
  logic [2:0] rtype_ctl;
  logic       retire;
  logic       pc_write, branch, ir_write, mem_write, reg_write, illegal;

  always_comb begin
    funct_ok  = 1'b1;
    rtype_ctl = ULA_ADD;
    case (Funct)
      6'b100000: rtype_ctl = ULA_ADD;
      6'b100010: rtype_ctl = ULA_SUB;
      6'b100100: rtype_ctl = ULA_AND;
      6'b100101: rtype_ctl = ULA_OR;
      6'b101010: rtype_ctl = ULA_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ULASrcA    = 1'b0;
    ULASrcB    = 2'b00;
    ULAControl = ULA_ADD;
    PCSrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        ULASrcB  = 2'b01;
        ir_write = MemReady;
        pc_write = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ULASrcB = 2'b11;
        case (OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            state_d = funct_ok ? S_EXEC : S_FETCH;
            illegal = ~funct_ok;
          end
          OP_BEQ:  state_d = S_BEQ;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ULASrcA    = 1'b1;
        ULAControl = rtype_ctl;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        RegDst    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        ULASrcA    = 1'b1;
        ULAControl = ULA_SUB;
        branch     = 1'b1;
        PCSrc      = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSrc    = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Reset leaves the FSM in FETCH; strobes are masked so nothing writes while held in reset.
  assign PCWrite    = pc_write  & rst_n;
  assign Branch     = branch    & rst_n;
  assign IRWrite    = ir_write  & rst_n;
  assign MemWrite   = mem_write & rst_n;
  assign RegWrite   = reg_write & rst_n;
  assign Illegal    = illegal   & rst_n;
  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and output
// vectors for each instruction class, stalls, illegal decode and reset behaviour.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  OP, Funct;
  logic        MemReady;
  logic        PCWrite, Branch, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
  logic        ULASrcA, Illegal;
  logic [1:0]  ULASrcB, PCSrc;
  logic [2:0]  ULAControl;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ULAControl(ULAControl), .PCSrc(PCSrc),
    .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  // {PCWrite,Branch,IorD,IRWrite,MemWrite,RegWrite,RegDst,MemtoReg, ULASrcA, ULASrcB, ULAControl, PCSrc, Illegal}
  logic [17:0] obs;
  assign obs = {PCWrite, Branch, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
                ULASrcA, ULASrcB, ULAControl, PCSrc, Illegal};

  localparam logic [17:0] E_FETCH   = {8'b1001_0000, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_IDLE    = {8'b0000_0000, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_DECODE  = {8'b0000_0000, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_DEC_ILL = {8'b0000_0000, 1'b0, 2'b11, 3'b010, 2'b00, 1'b1};
  localparam logic [17:0] E_MEMADR  = {8'b0000_0000, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_MEMRD   = {8'b0010_0000, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_MEMWB   = {8'b0000_0101, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_MEMWR   = {8'b0010_1000, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_ALUWB   = {8'b0000_0110, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_BEQ     = {8'b0100_0000, 1'b1, 2'b00, 3'b110, 2'b01, 1'b0};
  localparam logic [17:0] E_ADDIEX  = {8'b0000_0000, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_ADDIWB  = {8'b0000_0100, 1'b0, 2'b00, 3'b010, 2'b00, 1'b0};
  localparam logic [17:0] E_JUMP    = {8'b1000_0000, 1'b0, 2'b00, 3'b010, 2'b10, 1'b0};

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0]  st [5];
    logic [17:0] eo [5];
    rst_n = 1'b1; MemReady = 1'b1; OP = 6'b100011; Funct = 6'b000000;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || obs !== E_IDLE)
      $display("FAIL reset_async: state=%0d cnt=%0d outs=%b, expected state=0 cnt=0 outs=%b",
               State, InstrCount, obs, E_IDLE);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || obs !== E_IDLE)
      $display("FAIL reset_held: state=%0d cnt=%0d outs=%b, expected state=0 cnt=0 outs=%b",
               State, InstrCount, obs, E_IDLE);
    else n_pass++;
    rst_n = 1'b1;
    exp_cnt = '0;
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    eo = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (State !== st[i] || obs !== eo[i])
        $display("FAIL lw cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, State, obs, st[i], eo[i]);
      else n_pass++;
      tick();
    end
    exp_cnt++;
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== exp_cnt)
      $display("FAIL lw_end: state=%0d cnt=%0d, expected state=0 cnt=%0d", State, InstrCount, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_sw_stall();
    logic [3:0]  st [7];
    logic [17:0] eo [7];
    logic        mr [7];
    OP = 6'b101011; Funct = 6'b000000;
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    eo = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      #1;
      n_checks++;
      if (State !== st[i] || obs !== eo[i] || InstrCount !== exp_cnt)
        $display("FAIL sw cyc%0d: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 i, State, obs, InstrCount, st[i], eo[i], exp_cnt);
      else n_pass++;
      tick();
    end
    exp_cnt++;
    MemReady = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== exp_cnt)
      $display("FAIL sw_end: state=%0d cnt=%0d, expected state=0 cnt=%0d", State, InstrCount, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [5];
    logic [2:0]  ctl [5];
    logic [3:0]  st  [4];
    logic [17:0] eo  [4];
    fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ctl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    st  = '{4'd0, 4'd1, 4'd6, 4'd7};
    MemReady = 1'b1;
    for (int f = 0; f < 5; f++) begin
      OP = 6'b000000; Funct = fn[f];
      eo = '{E_FETCH, E_DECODE, {8'b0000_0000, 1'b1, 2'b00, ctl[f], 2'b00, 1'b0}, E_ALUWB};
      for (int i = 0; i < 4; i++) begin
        #1;
        n_checks++;
        if (State !== st[i] || obs !== eo[i])
          $display("FAIL rtype f=%b cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                   fn[f], i, State, obs, st[i], eo[i]);
        else n_pass++;
        tick();
      end
      exp_cnt++;
      #1;
      n_checks++;
      if (State !== 4'd0 || InstrCount !== exp_cnt)
        $display("FAIL rtype_end f=%b: state=%0d cnt=%0d, expected state=0 cnt=%0d",
                 fn[f], State, InstrCount, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_stall();
    OP = 6'b000000; Funct = 6'b100000; MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (State !== 4'd0 || obs !== E_IDLE)
        $display("FAIL fetch_stall cyc%0d: state=%0d outs=%b, expected state=0 outs=%b",
                 i, State, obs, E_IDLE);
      else n_pass++;
      tick();
    end
    MemReady = 1'b1;
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    logic [5:0] fns [2];
    ops = '{6'b000000, 6'b111111};
    fns = '{6'b000111, 6'b100000};
    MemReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      OP = ops[k]; Funct = fns[k];
      #1;
      n_checks++;
      if (State !== 4'd0 || obs !== E_FETCH)
        $display("FAIL illegal%0d fetch: state=%0d outs=%b, expected state=0 outs=%b",
                 k, State, obs, E_FETCH);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if (State !== 4'd1 || obs !== E_DEC_ILL)
        $display("FAIL illegal%0d decode: state=%0d outs=%b, expected state=1 outs=%b",
                 k, State, obs, E_DEC_ILL);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if (State !== 4'd0 || Illegal !== 1'b0 || InstrCount !== exp_cnt)
        $display("FAIL illegal%0d after: state=%0d ill=%b cnt=%0d, expected state=0 ill=0 cnt=%0d",
                 k, State, Illegal, InstrCount, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [10];
    logic [3:0]  st  [10];
    logic [17:0] eo  [10];
    ops = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010,
            6'b001000, 6'b001000, 6'b001000, 6'b001000};
    st  = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd11, 4'd0, 4'd1, 4'd9, 4'd10};
    eo  = '{E_FETCH, E_DECODE, E_BEQ, E_FETCH, E_DECODE, E_JUMP,
            E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB};
    MemReady = 1'b1; Funct = 6'b000000;
    for (int i = 0; i < 10; i++) begin
      OP = ops[i];
      #1;
      n_checks++;
      if (State !== st[i] || obs !== eo[i])
        $display("FAIL mixed cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, State, obs, st[i], eo[i]);
      else n_pass++;
      tick();
    end
    exp_cnt = exp_cnt + 32'd3;
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== exp_cnt)
      $display("FAIL mixed_end: state=%0d cnt=%0d, expected state=0 cnt=%0d", State, InstrCount, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    OP = 6'b001000; Funct = 6'b000000; MemReady = 1'b1;
    repeat (2) tick();
    #1;
    n_checks++;
    if (State !== 4'd9)
      $display("FAIL midrst_pre: state=%0d, expected state=9", State);
    else n_pass++;
    rst_n = 1'b0;
    exp_cnt = '0;
    #1;
    n_checks++;
    if (State !== 4'd0 || InstrCount !== 32'd0 || RegWrite !== 1'b0)
      $display("FAIL midrst_async: state=%0d cnt=%0d regwrite=%b, expected state=0 cnt=0 regwrite=0",
               State, InstrCount, RegWrite);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (State !== 4'd0 || InstrCount !== 32'd0 || RegWrite !== 1'b0)
        $display("FAIL midrst_after cyc%0d: state=%0d cnt=%0d regwrite=%b, expected state=0 cnt=0 regwrite=0",
                 i, State, InstrCount, RegWrite);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sw_stall();
    test_rtype();
    test_fetch_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
